// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the mult/div HI/LO stage.
package mult_div_pkg;
  localparam int WORD      = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_t;
endpackage

// File: rtl/hilo_ctrl_div_core.sv
// Restoring signed divider: magnitude load, one shift/subtract step per cycle, sign-fixed results.
module div_core
  import mult_div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic [WORD-1:0] quo,
  output logic [WORD-1:0] rem
);
  logic [WORD-1:0] q_r, r_r, d_r;
  logic            neg_q, neg_r;
  logic [WORD:0]   shifted, trial;

  // One extra bit keeps the trial sign valid when |b| is 2^31.
  assign shifted = {r_r, q_r[WORD-1]};
  assign trial   = shifted - {1'b0, d_r};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      q_r   <= a[WORD-1] ? -a : a;
      d_r   <= b[WORD-1] ? -b : b;
      r_r   <= '0;
      neg_r <= a[WORD-1];
      neg_q <= a[WORD-1] ^ b[WORD-1];
    end else if (step) begin
      q_r <= {q_r[WORD-2:0], ~trial[WORD]};
      r_r <= trial[WORD] ? shifted[WORD-1:0] : trial[WORD-1:0];
    end
  end

  assign quo = neg_q ? -q_r : q_r;
  assign rem = neg_r ? -r_r : r_r;
endmodule

// File: rtl/hilo_ctrl.sv
// Mult/div control and HI/LO registers; multiplier is external, divider is the div_core iterator.
module hilo_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_low,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = (MULT_LAT >= DIV_STEPS) ? $clog2(MULT_LAT + 1) : CNT_W;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             dz_pend;
  logic             take_mul, take_div, take_dz, wr_hi, wr_lo, mul_wr, div_step, div_wr;
  logic [WIDTH-1:0] quo, rem;
  logic             b_zero, mul_last, div_last;

  assign b_zero   = (b == '0);
  assign mul_last = (cnt == CW'(MULT_LAT));
  assign div_last = (cnt == CW'(DIV_STEPS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (op_mult) state_n = MUL_WAIT;
                else if (op_div && !b_zero) state_n = DIV_RUN;
      MUL_WAIT: if (mul_last) state_n = IDLE;
      DIV_RUN:  if (div_last) state_n = DIV_FIX;
      DIV_FIX:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    take_mul = 1'b0;
    take_div = 1'b0;
    take_dz  = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    mul_wr   = 1'b0;
    div_step = 1'b0;
    div_wr   = 1'b0;
    case (state)
      IDLE: begin
        take_mul = op_mult;
        take_div = !op_mult && op_div && !b_zero;
        take_dz  = !op_mult && op_div && b_zero;
        wr_hi    = !op_mult && !op_div && mthi;
        wr_lo    = !op_mult && !op_div && mtlo;
      end
      MUL_WAIT: mul_wr   = mul_last;
      DIV_RUN:  div_step = 1'b1;
      DIV_FIX:  div_wr   = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dz_pend  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      hi       <= '0;
      low      <= '0;
    end else begin
      dz_pend <= take_dz;
      done    <= mul_wr | div_wr | dz_pend;
      if (take_mul) begin
        mul_a <= a;
        mul_b <= b;
        cnt   <= CW'(1);
      end else if (take_div) begin
        cnt <= '0;
      end else if (state == MUL_WAIT || state == DIV_RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (take_dz)                  div_zero <= 1'b1;
      else if (take_mul || take_div) div_zero <= 1'b0;
      // Multiplier port words arrive swapped: mul_low carries the upper product half.
      if (mul_wr) begin
        hi  <= mul_low;
        low <= mul_hi;
      end else if (div_wr) begin
        hi  <= rem;
        low <= quo;
      end else begin
        if (wr_hi) hi  <= wdata;
        if (wr_lo) low <= wdata;
      end
    end
  end

  div_core u_div (
    .clk   (clk),
    .reset (reset),
    .load  (take_div),
    .step  (div_step),
    .a     (a),
    .b     (b),
    .quo   (quo),
    .rem   (rem)
  );
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural model of the external Booth multiplier.
module tb_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset, op_mult, op_div, mthi, mtlo;
  logic [31:0] a, b, wdata, mul_a, mul_b, mul_hi, mul_low, hi, low;
  logic        busy, done, div_zero;
  logic signed [63:0] prod;
  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  assign prod    = 64'($signed(mul_a)) * 64'($signed(mul_b));
  assign mul_hi  = prod[31:0];
  assign mul_low = prod[63:32];

  hilo_ctrl #(.WIDTH(32), .MULT_LAT(2)) dut (
    .clk(clk), .reset(reset), .op_mult(op_mult), .op_div(op_div),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_hi(mul_hi), .mul_low(mul_low),
    .hi(hi), .low(low), .busy(busy), .done(done), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start at edge 0, return the number of further edges until done rises.
  task automatic run_op(input logic m, input logic d, input logic [31:0] ta, input logic [31:0] tb_,
                        output int cyc);
    op_mult = m; op_div = d; a = ta; b = tb_;
    tick();
    op_mult = 1'b0; op_div = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b0; op_mult = 1'b0; op_div = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_low", low, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_flags", {busy, done, div_zero}, 0);
    reset = 1'b1;
    tick();

    // 7 * -3 = -21
    op_mult = 1'b1; a = 32'd7; b = 32'hFFFF_FFFD;
    tick();
    op_mult = 1'b0;
    chk("mul_busy", busy, 1);
    chk("mul_ops", {mul_a, mul_b}, {32'd7, 32'hFFFF_FFFD});
    tick();
    chk("mul_e1_done", done, 0);
    tick();
    chk("mul_e2_done", {done, busy}, 2'b10);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_low", low, 32'hFFFF_FFEB);
    tick();
    chk("mul_done_pulse", done, 0);

    // -7 / 2 -> q=-3, r=-1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lat", n, 33);
    chk("div_low", low, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dz", div_zero, 0);

    // Divide by zero leaves preloaded HI/LO intact
    mthi = 1'b1; wdata = 32'h11;
    tick();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    tick();
    mtlo = 1'b0;
    chk("mt_hilo", {hi, low}, {32'h11, 32'h22});
    run_op(1'b0, 1'b1, 32'd5, 32'd0, n);
    chk("dz_lat", n, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_hilo", {hi, low}, {32'h11, 32'h22});
    tick();
    chk("dz_done_pulse", done, 0);

    // Overflow case wraps; start clears div_zero
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("ovf_lat", n, 33);
    chk("ovf_low", low, 32'h8000_0000);
    chk("ovf_hi", hi, 0);
    chk("ovf_dz", div_zero, 0);
    run_op(1'b1, 1'b0, 32'h1_0000, 32'h1_0000, n);
    chk("big_lat", n, 2);
    chk("big_hilo", {hi, low}, {32'd1, 32'd0});

    // Starts and mthi while dividing are dropped: -100 / 7 -> q=-14, r=-2
    op_div = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7;
    tick();
    op_div = 1'b0;
    repeat (5) tick();
    op_mult = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    op_mult = 1'b0; mthi = 1'b1; wdata = 32'hDEAD;
    tick();
    mthi = 1'b0;
    chk("mid_busy", busy, 1);
    n = 7;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("mid_lat", n, 33);
    chk("mid_low", low, 32'hFFFF_FFF2);
    chk("mid_hi", hi, 32'hFFFF_FFFE);
    chk("mid_mul_a", mul_a, 32'h1_0000);

    // Back-to-back start in the done cycle: -2 * 6 = -12
    run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd6, n);
    chk("b2b_lat", n, 2);
    chk("b2b_hilo", {hi, low}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});

    // Async reset at divide step 10 aborts with everything cleared
    op_div = 1'b1; a = 32'd1000; b = 32'd3;
    tick();
    op_div = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_hilo", {hi, low}, 0);
    chk("arst_mul", {mul_a, mul_b}, 0);
    chk("arst_flags", {busy, done, div_zero}, 0);
    tick();
    reset = 1'b1;
    tick();
    run_op(1'b1, 1'b0, 32'd3, 32'd4, n);
    chk("post_lat", n, 2);
    chk("post_hilo", {hi, low}, {32'd0, 32'd12});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
